logic_unit_serial: RTL and testbench

LOGIC_UNIT_SERIAL -- requirements
Module: logic_unit_serial

---
 rtl/logic_unit_serial_if.sv | 35 +++
 rtl/logic_unit_serial.sv | 99 +++++++++
 tb/tb_logic_unit_serial.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/logic_unit_serial_if.sv
// Operand/result handshake bundle for logic_unit_serial.
// LOGIC_UNIT_SERIAL_ZERO_FLAG_EN adds the registered zero flag.
interface logic_unit_serial_if;
    logic [31:0] I1;
    logic [31:0] I2;
    logic [1:0]  op;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] O;
    logic        out_valid;
    logic        out_ready;
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
    logic        zero;

    modport master (
        output I1, I2, op, in_valid, out_ready,
        input  in_ready, O, out_valid, zero
    );

    modport slave (
        input  I1, I2, op, in_valid, out_ready,
        output in_ready, O, out_valid, zero
    );
`else
    modport master (
        output I1, I2, op, in_valid, out_ready,
        input  in_ready, O, out_valid
    );

    modport slave (
        input  I1, I2, op, in_valid, out_ready,
        output in_ready, O, out_valid
    );
`endif
endinterface

// File: rtl/logic_unit_serial.sv
// Byte-serial 32-bit AND/OR/XOR/NOR unit: one result byte per cycle, LSB first.
// Optional zero-result flag enabled by LOGIC_UNIT_SERIAL_ZERO_FLAG_EN.
module logic_unit_serial (
    input logic             clk,
    input logic             reset,
    logic_unit_serial_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] o_q;
    logic [1:0]  op_q;
    logic [1:0]  cnt_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [7:0]  byte_res;

    always_comb begin
        a_byte = a_q[8*cnt_q +: 8];
        b_byte = b_q[8*cnt_q +: 8];
        unique case (op_q)
            2'b00:   byte_res = a_byte & b_byte;
            2'b01:   byte_res = a_byte | b_byte;
            2'b10:   byte_res = a_byte ^ b_byte;
            default: byte_res = ~(a_byte | b_byte);
        endcase
    end

`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (state == StBusy && cnt_q == 2'd3) begin
            // Upper byte is still being written, so test the assembled word.
            zero_q <= ({byte_res, o_q[23:0]} == 32'h0);
        end
    end

    assign bus.zero = zero_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            o_q         <= 32'h0;
            op_q        <= 2'b00;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.I1;
                        b_q        <= bus.I2;
                        op_q       <= bus.op;
                        o_q        <= 32'h0;
                        cnt_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        state      <= StBusy;
                    end
                end
                StBusy: begin
                    o_q[8*cnt_q +: 8] <= byte_res;
                    if (cnt_q == 2'd3) begin
                        out_valid_q <= 1'b1;
                        state       <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state       <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.O         = o_q;
endmodule

// File: tb/tb_logic_unit_serial.sv
// Randomized self-checking bench for logic_unit_serial against a word-level model.
// Zero-flag checks compile in when LOGIC_UNIT_SERIAL_ZERO_FLAG_EN is defined.
module tb_logic_unit_serial;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic_unit_serial_if bus ();

    logic_unit_serial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic scramble();
        bus.I1       = $urandom;
        bus.I2       = $urandom;
        bus.op       = 2'($urandom_range(0, 3));
        bus.in_valid = 1'($urandom_range(0, 1));
    endtask

    // Issue one op, check the byte-by-byte build-up, hold off for `delay` cycles, hand off.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input int delay);
        logic [31:0] exp;
        logic [31:0] mask;
        int          cyc;
        exp = ref_op(a, b, op);
        check("idle_in_ready", 32'(bus.in_ready), 32'h1);
        bus.I1 = a;
        bus.I2 = b;
        bus.op = op;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("accept_clear_O", bus.O, 32'h0);
        check("busy_in_ready", 32'(bus.in_ready), 32'h0);
        cyc = 0;
        while (cyc < 20) begin
            scramble();
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            mask = (cyc >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * cyc)) - 32'h1);
            check("partial_O", bus.O, exp & mask);
            if (bus.out_valid) break;
        end
        check("latency", 32'(cyc), 32'd4);
        check("result", bus.O, exp);
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
        check("zero_flag", 32'(bus.zero), 32'(exp == 32'h0));
`endif
        for (int i = 0; i < delay; i++) begin
            scramble();
            bus.out_ready = 1'b0;
            @(negedge clk);
            check("hold_O", bus.O, exp);
            check("hold_out_valid", 32'(bus.out_valid), 32'h1);
            check("hold_in_ready", 32'(bus.in_ready), 32'h0);
        end
        scramble();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("handoff_out_valid", 32'(bus.out_valid), 32'h0);
        check("handoff_in_ready", 32'(bus.in_ready), 32'h1);
        check("handoff_O_kept", bus.O, exp);
    endtask

    initial begin
        logic seen_valid;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        bus.I1 = 32'h0;
        bus.I2 = 32'h0;
        bus.op = 2'b00;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_O", bus.O, 32'h0);
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
        check("rst_zero", 32'(bus.zero), 32'h0);
`endif

        run_op(32'h0F0F_0000, 32'h00FF_0000, 2'b11, 0);
        run_op(32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 0);
        run_op(32'hAAAA_5555, 32'hFFFF_0000, 2'b01, 1);
        run_op(32'hAAAA_5555, 32'hFFFF_0000, 2'b10, 2);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 10);
        run_op(32'h1234_5678, 32'h1234_5678, 2'b10, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 2'b01, 0);

        // Reset during the second busy cycle must drop the op silently.
        bus.I1 = 32'hDEAD_BEEF;
        bus.I2 = 32'h1234_5678;
        bus.op = 2'b01;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("busy_rst_O", bus.O, 32'h0);
        check("busy_rst_in_ready", 32'(bus.in_ready), 32'h1);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        check("busy_rst_no_valid", 32'(seen_valid), 32'h0);
        bus.out_ready = 1'b0;
        run_op(32'h0, 32'h0, 2'b11, 0);

        for (int n = 0; n < 25; n++) begin
            run_op($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end
        for (int n = 0; n < 4; n++) begin
            logic [31:0] v;
            v = $urandom;
            run_op(v, v, 2'b10, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
